// File: rtl/text_scroll_pkg.sv
// Shared types and constants for the text scroll sequencer and its glyph ROM.
package text_scroll_pkg;

  localparam int CHAR_W       = 7;
  localparam int COL_W        = 8;
  localparam int GLYPH_COLS   = 8;
  localparam int RAW_FLAG_BIT = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2,
    GAP   = 2'd3
  } state_e;

  // A raw character is shown as its six payload bits, framed by blank top and bottom rows.
  function automatic logic [COL_W-1:0] raw_column(input logic [CHAR_W-1:0] c);
    return {1'b0, c[RAW_FLAG_BIT-1:0], 1'b0};
  endfunction

endpackage

// File: rtl/glyph_col_rom.sv
// Combinational 5x7 font: glyph code (ASCII minus 0x20) and column index -> column bits.
// Each glyph uses columns 1..6; columns 0 and 7 are blank spacing. Unknown codes are blank.
module glyph_col_rom
  import text_scroll_pkg::*;
(
  input  logic [5:0]       code,
  input  logic [2:0]       col,
  output logic [COL_W-1:0] data
);

  // Six packed columns, column 1 in the most significant byte.
  logic [47:0] glyph;

  // Font table lookup by glyph code.
  always_comb begin
    glyph = '0;
    case (code)
      6'h00: glyph = 48'h00_00_00_00_00_00; // ' '
      6'h01: glyph = 48'h00_00_5F_00_00_00; // '!'
      6'h10: glyph = 48'h3E_51_49_45_3E_00; // '0'
      6'h11: glyph = 48'h00_42_7F_40_00_00; // '1'
      6'h12: glyph = 48'h42_61_51_49_46_00; // '2'
      6'h13: glyph = 48'h21_41_45_4B_31_00; // '3'
      6'h14: glyph = 48'h18_14_12_7F_10_00; // '4'
      6'h15: glyph = 48'h27_45_45_45_39_00; // '5'
      6'h16: glyph = 48'h3C_4A_49_49_30_00; // '6'
      6'h17: glyph = 48'h01_71_09_05_03_00; // '7'
      6'h18: glyph = 48'h36_49_49_49_36_00; // '8'
      6'h19: glyph = 48'h06_49_49_29_1E_00; // '9'
      6'h21: glyph = 48'h7C_12_11_11_12_7C; // 'A'
      6'h22: glyph = 48'h7F_49_49_49_49_36; // 'B'
      6'h23: glyph = 48'h3E_41_41_41_41_22; // 'C'
      6'h24: glyph = 48'h7F_41_41_41_22_1C; // 'D'
      6'h25: glyph = 48'h7F_49_49_49_41_41; // 'E'
      6'h28: glyph = 48'h7F_08_08_08_08_7F; // 'H'
      6'h29: glyph = 48'h00_41_41_7F_41_41; // 'I'
      6'h2C: glyph = 48'h7F_40_40_40_40_40; // 'L'
      6'h2F: glyph = 48'h3E_41_41_41_41_3E; // 'O'
      default: glyph = '0;
    endcase
  end

  // Column select; the outer columns are always blank.
  always_comb begin
    data = '0;
    case (col)
      3'd1:    data = glyph[47:40];
      3'd2:    data = glyph[39:32];
      3'd3:    data = glyph[31:24];
      3'd4:    data = glyph[23:16];
      3'd5:    data = glyph[15:8];
      3'd6:    data = glyph[7:0];
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/text_scroll_sequencer.sv
// Circular character buffer plus column streamer for the LED scroll display.
// Characters are written while idle; on play the buffer is walked oldest-first and each
// character is expanded into display columns, paced by an optional idle gap per column.
module text_scroll_sequencer
  import text_scroll_pkg::*;
#(
  parameter int WORD_COUNT = 20,
  parameter int RATE_DIV   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [CHAR_W-1:0] wr_char,
  input  logic              clear,
  input  logic              play,
  output logic              col_valid,
  input  logic              col_ready,
  output logic [COL_W-1:0]  col_data,
  output logic              frame_start
);

  localparam int PTR_W = $clog2(WORD_COUNT + 1);
  localparam int GAP_W = (RATE_DIV > 0) ? $clog2(RATE_DIV + 1) : 1;

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(WORD_COUNT - 1);
  localparam logic [PTR_W-1:0] FULL_LEN = PTR_W'(WORD_COUNT);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (RATE_DIV > 0) ? GAP_W'(RATE_DIV - 1) : '0;

  localparam logic [2:0] LAST_COL = 3'(GLYPH_COLS - 1);

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W-1:0]  len_q, len_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]        col_idx_q, col_idx_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              col_valid_q, col_valid_d;
  logic              frame_start_q, frame_start_d;
  logic              wr_ready_q, wr_ready_d;
  logic [COL_W-1:0]  col_data_q, col_data_d;
  logic [CHAR_W-1:0] cur_char_q, cur_char_d;

  logic [CHAR_W-1:0] mem_q [WORD_COUNT];

  logic              wr_en;
  logic [PTR_W-1:0]  len_c, tail_c;
  logic [PTR_W-1:0]  newest_ptr, rd_ptr_adv;
  logic              char_last;
  logic              load_new;
  logic              load_oldest;
  logic [CHAR_W-1:0] load_char;
  logic [2:0]        load_idx;
  logic [COL_W-1:0]  rom_col;
  logic [COL_W-1:0]  load_col;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_ONE;
  endfunction

  // wr_ready is only ever high while idle, so this is the single buffer write path.
  assign wr_en = wr_valid & wr_ready_q;

  // Read-side pointer bookkeeping: the newest entry sits just behind the head.
  always_comb begin
    newest_ptr = (head_q == '0) ? LAST_IDX : head_q - PTR_ONE;
    rd_ptr_adv = (rd_ptr_q == newest_ptr) ? tail_q : next_ptr(rd_ptr_q);
    char_last  = !cur_char_q[RAW_FLAG_BIT] || (col_idx_q == LAST_COL);
  end

  // Select the character/column that will be presented next; a new character is read
  // straight from the buffer so a gap can hand over to EMIT without an extra fetch cycle.
  always_comb begin
    load_new    = (state_q == FETCH) || ((state_q == GAP) && (col_idx_q == 3'd0));
    load_char   = load_new ? mem_q[rd_ptr_q] : cur_char_q;
    load_idx    = (state_q == EMIT) ? col_idx_q + 3'd1 : col_idx_q;
    load_oldest = load_new && (rd_ptr_q == tail_q);
  end

  glyph_col_rom u_rom (
    .code (load_char[5:0]),
    .col  (load_idx),
    .data (rom_col)
  );

  assign load_col = load_char[RAW_FLAG_BIT] ? rom_col : raw_column(load_char);

  // Next-state, buffer bookkeeping and registered output values.
  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    tail_d        = tail_q;
    len_d         = len_q;
    rd_ptr_d      = rd_ptr_q;
    col_idx_d     = col_idx_q;
    gap_cnt_d     = gap_cnt_q;
    col_valid_d   = col_valid_q;
    frame_start_d = frame_start_q;
    col_data_d    = col_data_q;
    cur_char_d    = cur_char_q;
    len_c         = len_q;
    tail_c        = tail_q;

    case (state_q)
      IDLE: begin
        // Clear lands before a same-cycle write, so the write becomes the only entry.
        if (clear) begin
          len_c  = '0;
          tail_c = head_q;
        end
        len_d  = len_c;
        tail_d = tail_c;
        if (wr_en) begin
          head_d = next_ptr(head_q);
          if (len_c == FULL_LEN) begin
            tail_d = next_ptr(tail_c);
          end else begin
            len_d = len_c + PTR_ONE;
          end
        end
        if (play && (len_d != '0)) begin
          state_d   = FETCH;
          rd_ptr_d  = tail_d;
          col_idx_d = 3'd0;
        end
      end

      FETCH: begin
        if (!play) begin
          state_d = IDLE;
        end else begin
          state_d       = EMIT;
          cur_char_d    = load_char;
          col_valid_d   = 1'b1;
          col_data_d    = load_col;
          frame_start_d = load_oldest;
        end
      end

      EMIT: begin
        // The column is held until the sink takes it, even if play has dropped.
        if (col_ready) begin
          col_valid_d   = 1'b0;
          frame_start_d = 1'b0;
          if (char_last) begin
            col_idx_d = 3'd0;
            rd_ptr_d  = rd_ptr_adv;
          end else begin
            col_idx_d = col_idx_q + 3'd1;
          end
          if (!play) begin
            state_d = IDLE;
          end else if (RATE_DIV > 0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
          end else if (char_last) begin
            state_d = FETCH;
          end else begin
            col_valid_d = 1'b1;
            col_data_d  = load_col;
          end
        end
      end

      GAP: begin
        if (!play) begin
          state_d = IDLE;
        end else if (gap_cnt_q == '0) begin
          state_d       = EMIT;
          cur_char_d    = load_char;
          col_valid_d   = 1'b1;
          col_data_d    = load_col;
          frame_start_d = load_oldest;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end

      default: begin
        state_d       = IDLE;
        col_valid_d   = 1'b0;
        frame_start_d = 1'b0;
      end
    endcase

    wr_ready_d = (state_d == IDLE) && !play;
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      head_q        <= '0;
      tail_q        <= '0;
      len_q         <= '0;
      rd_ptr_q      <= '0;
      col_idx_q     <= '0;
      gap_cnt_q     <= '0;
      col_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      wr_ready_q    <= 1'b0;
      col_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      len_q         <= len_d;
      rd_ptr_q      <= rd_ptr_d;
      col_idx_q     <= col_idx_d;
      gap_cnt_q     <= gap_cnt_d;
      col_valid_q   <= col_valid_d;
      frame_start_q <= frame_start_d;
      wr_ready_q    <= wr_ready_d;
      col_data_q    <= col_data_d;
    end
  end

  // Character currently being expanded; pure data, no reset needed.
  always_ff @(posedge clk) begin
    cur_char_q <= cur_char_d;
  end

  // Character buffer storage.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[head_q] <= wr_char;
    end
  end

  assign wr_ready    = wr_ready_q;
  assign col_valid   = col_valid_q;
  assign col_data    = col_data_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_text_scroll_sequencer.sv
// Directed bench for text_scroll_sequencer: one DUT paced back-to-back, one with RATE_DIV=3.
module tb_text_scroll_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic [6:0] wr_char;
  logic       clear;
  logic       col_ready;
  logic       play0, play3;
  logic       wr_ready0, col_valid0, frame0;
  logic [7:0] col_data0;
  logic       wr_ready3, col_valid3, frame3;
  logic [7:0] col_data3;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_a [8];

  always #5 clk = ~clk;

  text_scroll_sequencer #(.WORD_COUNT(20), .RATE_DIV(0)) u_dut0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready0),
    .wr_char     (wr_char),
    .clear       (clear),
    .play        (play0),
    .col_valid   (col_valid0),
    .col_ready   (col_ready),
    .col_data    (col_data0),
    .frame_start (frame0)
  );

  text_scroll_sequencer #(.WORD_COUNT(20), .RATE_DIV(3)) u_dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready3),
    .wr_char     (wr_char),
    .clear       (clear),
    .play        (play3),
    .col_valid   (col_valid3),
    .col_ready   (col_ready),
    .col_data    (col_data3),
    .frame_start (frame3)
  );

  // Offer one character; both DUTs are idle whenever this is used.
  task automatic write_char(input logic [6:0] c);
    bit done;
    done = 0;
    @(negedge clk);
    wr_char  = c;
    wr_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (wr_ready0) begin
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL write_timeout: wr_ready never rose for char %h", c);
    end
  endtask

  task automatic clear_buf();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Wait for a handshake on the selected DUT and return the column taken.
  task automatic get_col(input bit sel, output logic [7:0] d, output logic f);
    bit got;
    got = 0;
    d = '0;
    f = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (sel ? (col_valid3 && col_ready) : (col_valid0 && col_ready)) begin
        d   = sel ? col_data3 : col_data0;
        f   = sel ? frame3 : frame0;
        got = 1;
      end
    end
    if (got) begin
      @(posedge clk);
    end else begin
      checks++;
      errors++;
      $display("FAIL col_timeout: no column from dut%0d", sel ? 3 : 0);
    end
  endtask

  task automatic stop_play();
    bit idle;
    idle = 0;
    @(negedge clk);
    play0 = 1'b0;
    play3 = 1'b0;
    for (int i = 0; i < 30 && !idle; i++) begin
      @(negedge clk);
      if (wr_ready0 && wr_ready3 && !col_valid0 && !col_valid3) idle = 1;
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL stop_idle: wr_ready0=%b wr_ready3=%b required 1", wr_ready0, wr_ready3);
    end
  endtask

  task automatic test_reset();
    #12;
    checks += 4;
    if (wr_ready0 !== 1'b0)  begin errors++; $display("FAIL rst_wr_ready: got %b required 0", wr_ready0); end
    if (col_valid0 !== 1'b0) begin errors++; $display("FAIL rst_col_valid: got %b required 0", col_valid0); end
    if (col_data0 !== 8'h00) begin errors++; $display("FAIL rst_col_data: got %h required 00", col_data0); end
    if (frame0 !== 1'b0)     begin errors++; $display("FAIL rst_frame: got %b required 0", frame0); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (wr_ready0 !== 1'b0) begin errors++; $display("FAIL rst_release_wr_ready: got %b required 0", wr_ready0); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (wr_ready0 !== 1'b1) begin errors++; $display("FAIL first_wr_ready: got %b required 1", wr_ready0); end
  endtask

  task automatic test_empty_play();
    bit seen;
    seen = 0;
    play0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (col_valid0) seen = 1;
    end
    checks += 2;
    if (seen)       begin errors++; $display("FAIL empty_play: got col_valid=1 required 0"); end
    if (wr_ready0 !== 1'b0) begin errors++; $display("FAIL empty_play_wr_ready: got %b required 0", wr_ready0); end
    play0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_glyph();
    logic [7:0] d;
    logic f;
    clear_buf();
    // Write and play in the same cycle: the write must count toward len.
    @(negedge clk);
    wr_char   = 7'h61;
    wr_valid  = 1'b1;
    play0     = 1'b1;
    col_ready = 1'b1;
    checks++;
    if (wr_ready0 !== 1'b1) begin errors++; $display("FAIL glyph_wr_ready: got %b required 1", wr_ready0); end
    @(posedge clk);
    @(negedge clk);
    wr_valid = 1'b0;
    checks++;
    if (col_valid0 !== 1'b0) begin errors++; $display("FAIL latency_n1: got col_valid=%b required 0", col_valid0); end
    @(posedge clk);
    @(negedge clk);
    checks += 3;
    if (col_valid0 !== 1'b1) begin errors++; $display("FAIL latency_n2: got col_valid=%b required 1", col_valid0); end
    if (col_data0 !== 8'h00) begin errors++; $display("FAIL glyph_col0: got %h required 00", col_data0); end
    if (frame0 !== 1'b1)     begin errors++; $display("FAIL glyph_frame0: got %b required 1", frame0); end
    @(posedge clk);
    for (int i = 1; i < 16; i++) begin
      get_col(1'b0, d, f);
      checks += 2;
      if (d !== exp_a[i % 8]) begin errors++; $display("FAIL glyph_col%0d: got %h required %h", i, d, exp_a[i % 8]); end
      if (f !== (i % 8 == 0)) begin errors++; $display("FAIL glyph_frame%0d: got %b required %b", i, f, (i % 8 == 0)); end
    end
    stop_play();
  endtask

  task automatic test_mixed();
    logic [7:0] d;
    logic f;
    logic [7:0] exp_m [10];
    exp_m = '{8'h2A, 8'h00, 8'h7C, 8'h12, 8'h11, 8'h11, 8'h12, 8'h7C, 8'h00, 8'h2A};
    clear_buf();
    write_char(7'h15);
    write_char(7'h61);
    @(negedge clk);
    play0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      get_col(1'b0, d, f);
      checks += 2;
      if (d !== exp_m[i]) begin errors++; $display("FAIL mixed_col%0d: got %h required %h", i, d, exp_m[i]); end
      if (f !== (i == 0 || i == 9)) begin errors++; $display("FAIL mixed_frame%0d: got %b required %b", i, f, (i == 0 || i == 9)); end
    end
    stop_play();
  endtask

  task automatic test_overwrite();
    logic [7:0] d;
    logic f;
    logic [7:0] e;
    clear_buf();
    for (int c = 1; c <= 21; c++) write_char(7'(c));
    @(negedge clk);
    play0 = 1'b1;
    for (int k = 0; k < 21; k++) begin
      if (k < 19)       e = 8'((k + 2) << 1);
      else if (k == 19) e = 8'h2A;
      else              e = 8'h04;
      get_col(1'b0, d, f);
      checks += 2;
      if (d !== e) begin errors++; $display("FAIL wrap_col%0d: got %h required %h", k, d, e); end
      if (f !== (k == 0 || k == 20)) begin errors++; $display("FAIL wrap_frame%0d: got %b required %b", k, f, (k == 0 || k == 20)); end
    end
    stop_play();
  endtask

  task automatic test_backpressure();
    logic [7:0] d;
    logic f;
    clear_buf();
    write_char(7'h61);
    @(negedge clk);
    play0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      get_col(1'b0, d, f);
      checks++;
      if (d !== exp_a[i]) begin errors++; $display("FAIL bp_pre%0d: got %h required %h", i, d, exp_a[i]); end
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (j == 0) col_ready = 1'b0;
      checks++;
      if (col_valid0 !== 1'b1 || col_data0 !== 8'h11) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid=%b data=%h required valid=1 data=11", j, col_valid0, col_data0);
      end
    end
    @(negedge clk);
    col_ready = 1'b1;
    checks++;
    if (col_valid0 !== 1'b1 || col_data0 !== 8'h11) begin
      errors++;
      $display("FAIL bp_release: got valid=%b data=%h required valid=1 data=11", col_valid0, col_data0);
    end
    @(posedge clk);
    for (int i = 4; i < 9; i++) begin
      get_col(1'b0, d, f);
      checks += 2;
      if (d !== exp_a[i % 8]) begin errors++; $display("FAIL bp_post%0d: got %h required %h", i, d, exp_a[i % 8]); end
      if (f !== (i == 8))     begin errors++; $display("FAIL bp_frame%0d: got %b required %b", i, f, (i == 8)); end
    end
    stop_play();
  endtask

  task automatic test_undefined();
    logic [7:0] d;
    logic f;
    clear_buf();
    write_char(7'h7F);
    @(negedge clk);
    play0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      get_col(1'b0, d, f);
      checks += 2;
      if (d !== 8'h00)      begin errors++; $display("FAIL undef_col%0d: got %h required 00", i, d); end
      if (f !== (i == 0))   begin errors++; $display("FAIL undef_frame%0d: got %b required %b", i, f, (i == 0)); end
    end
    stop_play();
  endtask

  task automatic test_rate_div();
    logic [7:0] d;
    logic f;
    int zeros;
    bit seen;
    clear_buf();
    write_char(7'h61);
    @(negedge clk);
    play3     = 1'b1;
    col_ready = 1'b1;
    get_col(1'b1, d, f);
    checks += 2;
    if (d !== 8'h00) begin errors++; $display("FAIL rate_col0: got %h required 00", d); end
    if (f !== 1'b1)  begin errors++; $display("FAIL rate_frame0: got %b required 1", f); end
    for (int g = 0; g < 2; g++) begin
      zeros = 0;
      seen  = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (col_valid3) seen = 1;
        else zeros++;
      end
      checks += 2;
      if (zeros != 3) begin errors++; $display("FAIL rate_gap%0d: got %0d idle cycles required 3", g, zeros); end
      if (col_data3 !== exp_a[g + 1]) begin errors++; $display("FAIL rate_col%0d: got %h required %h", g + 1, col_data3, exp_a[g + 1]); end
      @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (col_valid3 !== 1'b0) begin errors++; $display("FAIL rate_in_gap: got col_valid=%b required 0", col_valid3); end
    play3 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks += 2;
    if (wr_ready3 !== 1'b1)  begin errors++; $display("FAIL rate_stop_wr_ready: got %b required 1", wr_ready3); end
    if (col_valid3 !== 1'b0) begin errors++; $display("FAIL rate_stop_valid: got %b required 0", col_valid3); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (col_valid3) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rate_after_stop: got col_valid=1 required 0"); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_buf();
    write_char(7'h61);
    col_ready = 1'b0;
    @(negedge clk);
    play0 = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (col_valid0) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL midrst_setup: got col_valid=0 required 1"); end
    #2;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (col_valid0 !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b required 0", col_valid0); end
    if (col_data0 !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h required 00", col_data0); end
    if (frame0 !== 1'b0)     begin errors++; $display("FAIL midrst_frame: got %b required 0", frame0); end
    if (wr_ready0 !== 1'b0)  begin errors++; $display("FAIL midrst_wr_ready: got %b required 0", wr_ready0); end
    @(negedge clk);
    play0 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (wr_ready0 !== 1'b1) begin errors++; $display("FAIL midrst_ready_after: got %b required 1", wr_ready0); end
    play0     = 1'b1;
    col_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (col_valid0) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midrst_len0: got col_valid=1 required 0"); end
    play0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (wr_ready0 !== 1'b1) begin errors++; $display("FAIL midrst_final_ready: got %b required 1", wr_ready0); end
  endtask

  initial begin
    exp_a     = '{8'h00, 8'h7C, 8'h12, 8'h11, 8'h11, 8'h12, 8'h7C, 8'h00};
    rst_n     = 1'b0;
    wr_valid  = 1'b0;
    wr_char   = '0;
    clear     = 1'b0;
    col_ready = 1'b1;
    play0     = 1'b0;
    play3     = 1'b0;

    test_reset();
    test_empty_play();
    test_glyph();
    test_mixed();
    test_overwrite();
    test_backpressure();
    test_undefined();
    test_rate_div();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
